// File: rtl/adder_share_ctrl.sv
// Shares one external 8-bit CLA slice between two requesters, sequencing
// 8-bit ops in one adder pass and 16-bit ops in two with a registered carry.
module adder_share_ctrl #(
  parameter int unsigned ADDW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*ADDW-1:0]   req_a0,
  input  logic [2*ADDW-1:0]   req_b0,
  input  logic [2*ADDW-1:0]   req_a1,
  input  logic [2*ADDW-1:0]   req_b1,
  input  logic [1:0]          req_sub,
  input  logic [1:0]          req_wide,
  output logic [ADDW-1:0]     add_a,
  output logic [ADDW-1:0]     add_b,
  output logic                add_ci,
  input  logic [ADDW-1:0]     add_s,
  input  logic                add_co,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*ADDW-1:0]   rsp_sum,
  output logic                rsp_co,
  output logic                rsp_of
);

  localparam int unsigned OPW = 2 * ADDW;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t          state;
  logic [ADDW-1:0] a_hi;
  logic [ADDW-1:0] bc_hi;
  logic [ADDW-1:0] sum_lo;
  logic            wide_q;
  logic            id_q;
  logic            last_grant;

  logic [1:0]      grant;
  logic            accept;
  logic            sel;
  logic [OPW-1:0]  sel_a;
  logic [OPW-1:0]  sel_bc;
  logic            sel_sub;
  logic            sel_wide;
  logic            pass_of;

  // Round-robin grant, only offered while idle
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel       = grant[1];

  // Operand select and subtract conditioning (B inverted, carry-in 1)
  always_comb begin
    sel_sub  = sel ? req_sub[1]  : req_sub[0];
    sel_wide = sel ? req_wide[1] : req_wide[0];
    sel_a    = sel ? req_a1 : req_a0;
    sel_bc   = sel ? req_b1 : req_b0;
    if (sel_sub) sel_bc = ~sel_bc;
  end

  // Signed overflow of the pass currently on the adder
  assign pass_of = (add_a[ADDW-1] == add_b[ADDW-1]) && (add_s[ADDW-1] != add_a[ADDW-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_hi       <= '0;
      bc_hi      <= '0;
      sum_lo     <= '0;
      wide_q     <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      add_a      <= '0;
      add_b      <= '0;
      add_ci     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_co     <= 1'b0;
      rsp_of     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_hi       <= sel_a[OPW-1:ADDW];
            bc_hi      <= sel_bc[OPW-1:ADDW];
            wide_q     <= sel_wide;
            id_q       <= sel;
            last_grant <= sel;
            add_a      <= sel_a[ADDW-1:0];
            add_b      <= sel_bc[ADDW-1:0];
            add_ci     <= sel_sub;
            state      <= LO;
          end
        end
        LO: begin
          sum_lo <= add_s;
          if (wide_q) begin
            add_a  <= a_hi;
            add_b  <= bc_hi;
            add_ci <= add_co;
            state  <= HI;
          end else begin
            add_a     <= '0;
            add_b     <= '0;
            add_ci    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_sum   <= {{ADDW{1'b0}}, add_s};
            rsp_co    <= add_co;
            rsp_of    <= pass_of;
            state     <= RESP;
          end
        end
        HI: begin
          add_a     <= '0;
          add_b     <= '0;
          add_ci    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_sum   <= {add_s, sum_lo};
          rsp_co    <= add_co;
          rsp_of    <= pass_of;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: behavioural CLA slice, directed vectors,
// queue scoreboard checked by an independent response monitor.
module tb_adder_share_ctrl;

  typedef struct packed {
    logic        id;
    logic [15:0] sum;
    logic        co;
    logic        of;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_sub = 2'b00, req_wide = 2'b00;
  logic [7:0]  add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_co, rsp_of;

  int   n_vec  = 0;
  int   n_miss = 0;
  rsp_t exp_q[$];

  adder_share_ctrl #(.ADDW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sub(req_sub), .req_wide(req_wide),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co), .rsp_of(rsp_of)
  );

  // External combinational adder slice
  assign {add_co, add_s} = 9'(add_a) + 9'(add_b) + 9'(add_ci);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expectation per completed handshake
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_sum), 32'hFFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp", 32'({rsp_id, rsp_sum, rsp_co, rsp_of}), 32'(e));
      end
    end
  end

  task automatic drive(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic wide);
    if (id == 0) begin req_a0 = a; req_b0 = b; end
    else         begin req_a1 = a; req_b1 = b; end
    req_sub[id]   = sub;
    req_wide[id]  = wide;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_accept(input int id, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    // Scramble operands to show they were latched
    if (id == 0) begin req_a0 = 16'hDEAD; req_b0 = 16'hBEEF; end
    else         begin req_a1 = 16'hDEAD; req_b1 = 16'hBEEF; end
    req_sub[id]  = ~req_sub[id];
    req_wide[id] = ~req_wide[id];
  endtask

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic wide, input logic [15:0] exp_sum,
                       input logic exp_co, input logic exp_of, input logic exp_hi_ci);
    bit          ok;
    int          lat;
    logic [15:0] bc;
    bc = sub ? ~b : b;
    drive(id, a, b, sub, wide);
    wait_accept(id, ok);
    if (!ok) return;
    exp_q.push_back(rsp_t'{id[0], exp_sum, exp_co, exp_of});
    chk("lo_a", 32'(add_a), 32'(a[7:0]));
    chk("lo_b", 32'(add_b), 32'(bc[7:0]));
    chk("lo_ci", 32'(add_ci), 32'(sub));
    lat = 1;
    if (wide) begin
      @(posedge clk); #1; lat++;
      chk("hi_a", 32'(add_a), 32'(a[15:8]));
      chk("hi_b", 32'(add_b), 32'(bc[15:8]));
      chk("hi_ci", 32'(add_ci), 32'(exp_hi_ci));
    end
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid) break;
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), wide ? 32'd3 : 32'd2);
  endtask

  task automatic drain();
    for (int t = 0; t < 20; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    int got;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_of}), 32'd0);
    chk("rst_add", 32'({add_a, add_b, add_ci}), 32'd0);

    // Narrow/wide add and subtract, carry and overflow boundaries
    issue(0, 16'h0035, 16'h0047, 1'b0, 1'b0, 16'h007C, 1'b0, 1'b0, 1'b0);
    issue(1, 16'h12FF, 16'h0001, 1'b0, 1'b1, 16'h1300, 1'b0, 1'b0, 1'b1);
    issue(0, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    issue(0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0);
    issue(1, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
    issue(0, 16'h00F0, 16'h0020, 1'b1, 1'b0, 16'h00D0, 1'b1, 1'b0, 1'b0);
    drain();

    // Round robin from a fresh reset: grants 0,1,0,1
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    req_a0 = 16'h1234; req_b0 = 16'h0101; req_sub[0] = 1'b0; req_wide[0] = 1'b1;
    req_a1 = 16'h00F0; req_b1 = 16'h0020; req_sub[1] = 1'b1; req_wide[1] = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (|req_ready) begin got = 1; break; end
      end
      chk("rr_seen", 32'(got), 32'd1);
      chk("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k % 2 == 0) exp_q.push_back(rsp_t'{1'b0, 16'h1335, 1'b0, 1'b0});
      else            exp_q.push_back(rsp_t'{1'b1, 16'h00D0, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    drain();

    // Back-pressure: response held for 5 cycles with requesters waiting
    rsp_ready = 1'b0;
    drive(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_accept(0, ok);
    exp_q.push_back(rsp_t'{1'b0, 16'h0000, 1'b1, 1'b0});
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    req_a0 = 16'h0001; req_b0 = 16'h0001; req_a1 = 16'h0002; req_b1 = 16'h0002;
    req_valid = 2'b11;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'({rsp_id, rsp_sum, rsp_co, rsp_of}), 32'h0000_0002);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("stall_release", 32'(rsp_valid), 32'd0);
    chk("stall_popped", 32'(exp_q.size()), 32'd0);

    // Reset during the high pass drops the op
    drive(1, 16'h12FF, 16'h0001, 1'b0, 1'b1);
    wait_accept(1, ok);
    @(posedge clk); #1;
    chk("abort_hi_ci", 32'(add_ci), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_add", 32'({add_a, add_b, add_ci}), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    issue(0, 16'h0035, 16'h0047, 1'b0, 1'b0, 16'h007C, 1'b0, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired, vectors=%0d miscompares=%0d", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

endmodule
